// File: rtl/seg7_display_arbiter.sv
// Round-robin arbiter that lends one seven-segment display to N_REQ requesters.
// Each owner keeps the display for at least DWELL cycles, and a BLANK-cycle dark gap separates owners.
module seg7_display_arbiter #(
  parameter int N_REQ   = 4,
  parameter int W_DIGIT = 8,
  parameter int DWELL   = 27_000_000,
  parameter int BLANK   = 2_700_000,
  localparam int OW     = $clog2(N_REQ),
  localparam int WW     = W_DIGIT * 4,
  localparam int DCW    = (DWELL > 1) ? $clog2(DWELL) : 1,
  localparam int BCW    = (BLANK > 1) ? $clog2(BLANK) : 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*WW-1:0]        number_in,
  input  logic [N_REQ*W_DIGIT-1:0]   dots_in,
  output logic [N_REQ-1:0]           gnt,
  output logic [OW-1:0]              owner,
  output logic                       owner_valid,
  output logic [WW-1:0]              number,
  output logic [W_DIGIT-1:0]         dots
);

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_BLANK} state_t;

  state_t           state, nxt_state;
  logic [OW-1:0]    ptr, nxt_ptr, nxt_owner, win;
  logic [DCW-1:0]   dwell_cnt, nxt_dwell;
  logic [BCW-1:0]   blank_cnt, nxt_blank;
  logic             win_found, others, dwell_done;

  // Search starts one past the last owner, so the last owner is considered last.
  always_comb begin
    win_found = 1'b0;
    win       = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!win_found && req[(int'(ptr) + k) % N_REQ]) begin
        win_found = 1'b1;
        win       = OW'((int'(ptr) + k) % N_REQ);
      end
    end
  end

  assign others     = |(req & ~(N_REQ'(1) << owner));
  assign dwell_done = (dwell_cnt == DCW'(DWELL - 1));

  always_comb begin
    nxt_state = state;
    nxt_ptr   = ptr;
    nxt_owner = owner;
    nxt_dwell = dwell_cnt;
    nxt_blank = blank_cnt;
    unique case (state)
      ST_IDLE: begin
        if (win_found) begin
          nxt_state = ST_GRANT;
          nxt_owner = win;
          nxt_ptr   = win;
          nxt_dwell = '0;
        end
      end
      ST_GRANT: begin
        // A dropped request wins over dwell expiry; both lead to the same blank.
        if (!req[owner] || (dwell_done && others)) begin
          nxt_state = ST_BLANK;
          nxt_blank = '0;
        end else if (!dwell_done) begin
          nxt_dwell = dwell_cnt + 1'b1;
        end
      end
      ST_BLANK: begin
        if (blank_cnt == BCW'(BLANK - 1)) begin
          if (win_found) begin
            nxt_state = ST_GRANT;
            nxt_owner = win;
            nxt_ptr   = win;
            nxt_dwell = '0;
          end else begin
            nxt_state = ST_IDLE;
          end
        end else begin
          nxt_blank = blank_cnt + 1'b1;
        end
      end
      default: nxt_state = ST_IDLE;
    endcase
    if (nxt_state != ST_GRANT) nxt_owner = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      ptr       <= OW'(N_REQ - 1);
      dwell_cnt <= '0;
      blank_cnt <= '0;
    end else begin
      state     <= nxt_state;
      ptr       <= nxt_ptr;
      dwell_cnt <= nxt_dwell;
      blank_cnt <= nxt_blank;
    end
  end

  // Outputs are registered from the next state, so a new owner's word shows on the grant edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      gnt         <= '0;
      owner       <= '0;
      owner_valid <= 1'b0;
      number      <= '0;
      dots        <= '0;
    end else if (nxt_state == ST_GRANT) begin
      gnt         <= N_REQ'(1) << nxt_owner;
      owner       <= nxt_owner;
      owner_valid <= 1'b1;
      number      <= number_in[int'(nxt_owner)*WW +: WW];
      dots        <= dots_in[int'(nxt_owner)*W_DIGIT +: W_DIGIT];
    end else begin
      gnt         <= '0;
      owner       <= '0;
      owner_valid <= 1'b0;
      number      <= '0;
      dots        <= '0;
    end
  end

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Directed bench for seg7_display_arbiter with N_REQ=4, W_DIGIT=8, DWELL=4, BLANK=2.
module tb_seg7_display_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [127:0] number_in;
  logic [31:0] dots_in;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic        owner_valid;
  logic [31:0] number;
  logic [7:0]  dots;

  logic [31:0] nums [4];
  logic [7:0]  dts  [4];

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    int         own;
    logic       ov;
  } vec_t;

  vec_t tbl[$];

  assign number_in = {nums[3], nums[2], nums[1], nums[0]};
  assign dots_in   = {dts[3], dts[2], dts[1], dts[0]};

  seg7_display_arbiter #(.N_REQ(4), .W_DIGIT(8), .DWELL(4), .BLANK(2)) dut (
    .clock(clock), .reset(reset), .req(req), .number_in(number_in), .dots_in(dots_in),
    .gnt(gnt), .owner(owner), .owner_valid(owner_valid), .number(number), .dots(dots)
  );

  always #5 clock = ~clock;

  task automatic add(input logic [3:0] r, input logic [3:0] g, input int o, input logic v);
    vec_t e;
    e.req = r; e.gnt = g; e.own = o; e.ov = v;
    tbl.push_back(e);
  endtask

  task automatic chk(input string name, input logic [3:0] eg, input int eo, input logic ev,
                     input logic [31:0] en, input logic [7:0] ed);
    n_vec++;
    if (gnt !== eg || owner !== 2'(eo) || owner_valid !== ev || number !== en || dots !== ed) begin
      n_bad++;
      $display("FAIL %s: got gnt=%b owner=%0d valid=%b number=%h dots=%h, want gnt=%b owner=%0d valid=%b number=%h dots=%h",
               name, gnt, owner, owner_valid, number, dots, eg, eo, ev, en, ed);
    end
  endtask

  task automatic chk_std(input string name, input logic [3:0] eg, input int eo, input logic ev);
    chk(name, eg, eo, ev, ev ? nums[eo] : 32'h0, ev ? dts[eo] : 8'h0);
  endtask

  task automatic step(input logic [3:0] r);
    @(negedge clock);
    req = r;
    @(posedge clock);
    #1;
  endtask

  initial begin
    nums[0] = 32'hDEADBEEF; nums[1] = 32'h11111111; nums[2] = 32'h22222222; nums[3] = 32'h33333333;
    dts[0]  = 8'hA0; dts[1] = 8'hA1; dts[2] = 8'hA2; dts[3] = 8'hA3;
    reset = 1'b0;
    req   = 4'b0000;

    // req, gnt, owner, owner_valid after the edge
    add(4'b1111, 4'b0001, 0, 1); add(4'b1111, 4'b0001, 0, 1);
    add(4'b1111, 4'b0001, 0, 1); add(4'b1111, 4'b0001, 0, 1);
    add(4'b1111, 4'b0000, 0, 0); add(4'b1111, 4'b0000, 0, 0);
    add(4'b1111, 4'b0010, 1, 1);
    add(4'b1000, 4'b0000, 0, 0); add(4'b1000, 4'b0000, 0, 0);
    add(4'b1000, 4'b1000, 3, 1);
    add(4'b0100, 4'b0000, 0, 0); add(4'b0100, 4'b0000, 0, 0);
    for (int i = 0; i < 7; i++) add(4'b0100, 4'b0100, 2, 1);
    add(4'b0110, 4'b0000, 0, 0); add(4'b0110, 4'b0000, 0, 0);
    add(4'b0110, 4'b0010, 1, 1);
    for (int i = 0; i < 4; i++) add(4'b0000, 4'b0000, 0, 0);
    add(4'b0001, 4'b0001, 0, 1);
    for (int i = 0; i < 3; i++) add(4'b0011, 4'b0001, 0, 1);
    add(4'b0010, 4'b0000, 0, 0); add(4'b0000, 4'b0000, 0, 0);
    add(4'b1000, 4'b1000, 3, 1);
    for (int i = 0; i < 3; i++) add(4'b0000, 4'b0000, 0, 0);

    #3;
    chk_std("reset_values", 4'b0000, 0, 0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step(4'b0000);
      chk_std($sformatf("idle_%0d", i), 4'b0000, 0, 0);
    end

    foreach (tbl[i]) begin
      step(tbl[i].req);
      chk_std($sformatf("vec_%0d", i), tbl[i].gnt, tbl[i].own, tbl[i].ov);
    end

    // Sole requester 2: the word change shows one edge later.
    step(4'b0100);
    chk_std("sole_grant", 4'b0100, 2, 1);
    @(negedge clock);
    nums[2] = 32'h12345678;
    #1;
    chk("slice_not_yet", 4'b0100, 2, 1, 32'h22222222, 8'hA2);
    step(4'b0100);
    chk("slice_update", 4'b0100, 2, 1, 32'h12345678, 8'hA2);

    // Async reset in GRANT clears outputs without a clock edge.
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk("async_clear_grant", 4'b0000, 0, 0, 32'h0, 8'h0);
    @(negedge clock);
    req = 4'b1111;
    #1;
    reset = 1'b1;
    #2;
    chk("hold_until_edge", 4'b0000, 0, 0, 32'h0, 8'h0);
    @(posedge clock);
    #1;
    chk_std("first_after_reset", 4'b0001, 0, 1);
    for (int i = 0; i < 3; i++) step(4'b1111);
    step(4'b1111);
    chk_std("into_blank", 4'b0000, 0, 0);

    // Reset mid-BLANK must restart arbitration from requester 0.
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk_std("async_clear_blank", 4'b0000, 0, 0);
    @(negedge clock);
    reset = 1'b1;
    step(4'b1111);
    chk_std("regrant_req0", 4'b0001, 0, 1);

    // Rotation from power-up state: 4 grant cycles then 2 blank cycles per owner.
    @(negedge clock);
    reset = 1'b0;
    req   = 4'b0000;
    @(negedge clock);
    reset = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      int pos, o;
      step(4'b1111);
      pos = (k - 1) % 6;
      o   = ((k - 1) / 6) % 4;
      if (pos < 4) chk_std($sformatf("rot_%0d", k), 4'(1 << o), o, 1);
      else         chk_std($sformatf("rot_%0d", k), 4'b0000, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
